// File: rtl/colour_cfg_pkg.sv
// Shared definitions for the colour-filter configuration scheduler.
// Holds the configuration word field layout, the filter mode encodings and
// the scheduler FSM state type. No ports; imported by the RTL files.
package colour_cfg_pkg;

    // Configuration word layout: {mode[1:0], R_th[7:0], G_th[7:0], B_th[7:0]}
    localparam int unsigned MODE_MSB = 25;
    localparam int unsigned MODE_LSB = 24;
    localparam int unsigned MODE_W   = 2;
    localparam int unsigned R_LSB    = 16;
    localparam int unsigned G_LSB    = 8;
    localparam int unsigned B_LSB    = 0;
    localparam int unsigned TH_W     = 8;

    typedef enum logic [MODE_W-1:0] {
        MODE_PASS  = 2'b00,
        MODE_RED   = 2'b01,
        MODE_GREEN = 2'b10,
        MODE_BLUE  = 2'b11
    } mode_e;

    // PEND means the shadow register holds a value not yet committed.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

endpackage

// File: rtl/cfg_rr_arb.sv
// Two-input round-robin arbiter with eligibility already applied.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset (pointer returns to A)
//   eligible - bit 0 = requester A, bit 1 = requester B
//   grant    - one-hot grant, same bit order; all-zero when nobody is eligible
// The priority pointer only moves on a tie, and then points at the loser.
module cfg_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    // 0: A has priority on a tie, 1: B has priority.
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        unique case (eligible)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                grant = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/colour_cfg_scheduler.sv
// Frame-synchronous configuration scheduler for the colour filter.
// Arbitrates two requesters (A: switch host, B: SD preset loader) into a
// shadow register and commits the shadow to the live configuration only at
// the start of vertical sync, so a frame never mixes two configurations.
// Ports:
//   iCLK, iRST          - pixel clock, synchronous active-high reset
//   iVS                 - vertical sync, active low
//   iFREEZE             - defers commits while high
//   iA_REQ/iA_CFG/oA_ACK, iB_REQ/iB_CFG/oB_ACK - requester handshakes
//   oCFG, oCFG_VALID    - live configuration and one-cycle commit pulse
//   oPENDING            - shadow holds an uncommitted value
//   oFRAME_CNT          - wrapping count of iVS falling edges
module colour_cfg_scheduler
    import colour_cfg_pkg::*;
#(
    parameter int unsigned      CFGW      = 26,
    parameter logic [CFGW-1:0]  CFG_RESET = '0,
    parameter int unsigned      FCW       = 16
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iVS,
    input  logic            iFREEZE,
    input  logic            iA_REQ,
    input  logic [CFGW-1:0] iA_CFG,
    output logic            oA_ACK,
    input  logic            iB_REQ,
    input  logic [CFGW-1:0] iB_CFG,
    output logic            oB_ACK,
    output logic [CFGW-1:0] oCFG,
    output logic            oCFG_VALID,
    output logic            oPENDING,
    output logic [FCW-1:0]  oFRAME_CNT
);

    state_e          state_q;
    state_e          state_d;
    logic [CFGW-1:0] shadow_q;
    logic [CFGW-1:0] cfg_q;
    logic            cfg_valid_q;
    logic            a_ack_q;
    logic            b_ack_q;
    logic [FCW-1:0]  frame_cnt_q;
    // iVS is registered once, then edge-detected against its delayed copy,
    // so the commit lands one edge after iVS is first sampled low.
    logic            vs_sync_q;
    logic            vs_prev_q;

    logic            vs_fall;
    logic            commit;
    logic [1:0]      eligible;
    logic [1:0]      grant;
    logic            any_grant;
    logic [CFGW-1:0] grant_cfg;

    // A requester whose ACK is high this cycle is still holding REQ from the
    // grant it just received; masking it prevents a double grant.
    assign eligible  = {iB_REQ & ~b_ack_q, iA_REQ & ~a_ack_q};
    assign any_grant = |grant;
    assign grant_cfg = grant[1] ? iB_CFG : iA_CFG;
    assign vs_fall   = vs_prev_q & ~vs_sync_q;
    assign commit    = vs_fall & (state_q == PEND) & ~iFREEZE;

    cfg_rr_arb u_arb (
        .clk      (iCLK),
        .rst      (iRST),
        .eligible (eligible),
        .grant    (grant)
    );

    // FSM state register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a coincident grant keeps the shadow pending.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any_grant) state_d = PEND;
            PEND: if (commit && !any_grant) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output
    always_comb begin
        oPENDING = (state_q == PEND);
    end

    // Datapath: shadow, live config, handshakes, frame counter.
    // On a commit coincident with a grant, the old shadow is read before
    // the new value overwrites it.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            shadow_q    <= CFG_RESET;
            cfg_q       <= CFG_RESET;
            cfg_valid_q <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            frame_cnt_q <= '0;
            vs_sync_q   <= 1'b1;
            vs_prev_q   <= 1'b1;
        end else begin
            vs_sync_q   <= iVS;
            vs_prev_q   <= vs_sync_q;
            a_ack_q     <= grant[0];
            b_ack_q     <= grant[1];
            cfg_valid_q <= commit;
            if (vs_fall) begin
                frame_cnt_q <= frame_cnt_q + {{(FCW-1){1'b0}}, 1'b1};
            end
            if (commit) begin
                cfg_q <= shadow_q;
            end
            if (any_grant) begin
                shadow_q <= grant_cfg;
            end
        end
    end

    assign oCFG       = cfg_q;
    assign oCFG_VALID = cfg_valid_q;
    assign oA_ACK     = a_ack_q;
    assign oB_ACK     = b_ack_q;
    assign oFRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_colour_cfg_scheduler.sv
// Self-checking bench for colour_cfg_scheduler: per-cycle vector table with
// hand-computed expected outputs, plus a frame-counter wrap sequence run on a
// narrow-counter instance.
module tb_colour_cfg_scheduler;

    localparam int unsigned CFGW = 26;
    localparam int unsigned FCW  = 16;
    localparam int unsigned WFCW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            vs;
    logic            frz;
    logic            a_req;
    logic [CFGW-1:0] a_cfg;
    logic            a_ack;
    logic            b_req;
    logic [CFGW-1:0] b_cfg;
    logic            b_ack;
    logic [CFGW-1:0] cfg;
    logic            cfg_valid;
    logic            pending;
    logic [FCW-1:0]  frame_cnt;

    logic            w_rst;
    logic            w_vs;
    logic            w_a_ack;
    logic            w_b_ack;
    logic [CFGW-1:0] w_cfg;
    logic            w_cfg_valid;
    logic            w_pending;
    logic [WFCW-1:0] w_frame_cnt;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    colour_cfg_scheduler #(
        .CFGW      (CFGW),
        .CFG_RESET (26'h0),
        .FCW       (FCW)
    ) dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iVS        (vs),
        .iFREEZE    (frz),
        .iA_REQ     (a_req),
        .iA_CFG     (a_cfg),
        .oA_ACK     (a_ack),
        .iB_REQ     (b_req),
        .iB_CFG     (b_cfg),
        .oB_ACK     (b_ack),
        .oCFG       (cfg),
        .oCFG_VALID (cfg_valid),
        .oPENDING   (pending),
        .oFRAME_CNT (frame_cnt)
    );

    // Narrow frame counter so the wrap can be reached in a few cycles.
    colour_cfg_scheduler #(
        .CFGW      (CFGW),
        .CFG_RESET (26'h0),
        .FCW       (WFCW)
    ) dut_wrap (
        .iCLK       (clk),
        .iRST       (w_rst),
        .iVS        (w_vs),
        .iFREEZE    (1'b0),
        .iA_REQ     (1'b0),
        .iA_CFG     ('0),
        .oA_ACK     (w_a_ack),
        .iB_REQ     (1'b0),
        .iB_CFG     ('0),
        .oB_ACK     (w_b_ack),
        .oCFG       (w_cfg),
        .oCFG_VALID (w_cfg_valid),
        .oPENDING   (w_pending),
        .oFRAME_CNT (w_frame_cnt)
    );

    typedef struct {
        logic            rst;
        logic            vs;
        logic            frz;
        logic            a_req;
        logic [CFGW-1:0] a_cfg;
        logic            b_req;
        logic [CFGW-1:0] b_cfg;
        logic            e_a_ack;
        logic            e_b_ack;
        logic [CFGW-1:0] e_cfg;
        logic            e_valid;
        logic            e_pend;
        logic [FCW-1:0]  e_fc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic f,
                       input logic ar, input logic [CFGW-1:0] ac,
                       input logic br, input logic [CFGW-1:0] bc,
                       input logic ea, input logic eb, input logic [CFGW-1:0] ec,
                       input logic ev, input logic ep, input logic [FCW-1:0] efc);
        vec_t t;
        t.rst = r;  t.vs = v;  t.frz = f;
        t.a_req = ar;  t.a_cfg = ac;  t.b_req = br;  t.b_cfg = bc;
        t.e_a_ack = ea;  t.e_b_ack = eb;  t.e_cfg = ec;
        t.e_valid = ev;  t.e_pend = ep;  t.e_fc = efc;
        vecs.push_back(t);
    endtask

    initial begin
        // rst vs frz | aReq aCfg | bReq bCfg || aAck bAck cfg valid pend fc
        // Reset
        add(1, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 0, 0);
        // Single write from A, commit on the next vsync
        add(0, 1, 0, 1, 26'h1804020, 0, 0,            1, 0, 26'h0,       0, 1, 0);
        add(0, 1, 0, 1, 26'h1804020, 0, 0,            0, 0, 26'h0,       0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h1804020, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h1804020, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h1804020, 0, 0, 1);
        // Tie: A first, B next cycle, B's value commits
        add(0, 1, 0, 1, 26'h1000000, 1, 26'h2000000,  1, 0, 26'h1804020, 0, 1, 1);
        add(0, 1, 0, 1, 26'h1000000, 1, 26'h2000000,  0, 1, 26'h1804020, 0, 1, 1);
        add(0, 1, 0, 0, 0, 1, 26'h2000000,            0, 0, 26'h1804020, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h1804020, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h1804020, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h2000000, 1, 0, 2);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 0, 2);
        // Second tie: B first this time
        add(0, 1, 0, 1, 26'h0111111, 1, 26'h0222222,  0, 1, 26'h2000000, 0, 1, 2);
        add(0, 1, 0, 1, 26'h0111111, 1, 26'h0222222,  1, 0, 26'h2000000, 0, 1, 2);
        add(0, 1, 0, 1, 26'h0111111, 0, 0,            0, 0, 26'h2000000, 0, 1, 2);
        // Freeze across three falls, then commit after release
        add(0, 0, 1, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 2);
        add(0, 0, 1, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 3);
        add(0, 1, 1, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 3);
        add(0, 0, 1, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 3);
        add(0, 0, 1, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 4);
        add(0, 1, 1, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 4);
        add(0, 0, 1, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 4);
        add(0, 0, 1, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 5);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 5);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h2000000, 0, 1, 5);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h0111111, 1, 0, 6);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0111111, 0, 0, 6);
        // Coincident grant on the commit edge
        add(0, 1, 0, 1, 26'h3000000, 0, 0,            1, 0, 26'h0111111, 0, 1, 6);
        add(0, 1, 0, 1, 26'h3000000, 0, 0,            0, 0, 26'h0111111, 0, 1, 6);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0111111, 0, 1, 6);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h0111111, 0, 1, 6);
        add(0, 0, 0, 0, 0, 1, 26'h0FFFFFF,            0, 1, 26'h3000000, 1, 1, 7);
        add(0, 0, 0, 0, 0, 1, 26'h0FFFFFF,            0, 0, 26'h3000000, 0, 1, 7);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h3000000, 0, 1, 7);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h3000000, 0, 1, 7);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h0FFFFFF, 1, 0, 8);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0FFFFFF, 0, 0, 8);
        // Reset while pending discards the shadow
        add(0, 1, 0, 1, 26'h1234567, 0, 0,            1, 0, 26'h0FFFFFF, 0, 1, 8);
        add(0, 1, 0, 1, 26'h1234567, 0, 0,            0, 0, 26'h0FFFFFF, 0, 1, 8);
        add(1, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0,                      0, 0, 26'h0,       0, 0, 1);

        rst = 1'b1;  vs = 1'b1;  frz = 1'b0;
        a_req = 1'b0;  a_cfg = '0;  b_req = 1'b0;  b_cfg = '0;
        w_rst = 1'b1;  w_vs = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;  vs = vecs[i].vs;  frz = vecs[i].frz;
            a_req = vecs[i].a_req;  a_cfg = vecs[i].a_cfg;
            b_req = vecs[i].b_req;  b_cfg = vecs[i].b_cfg;
            @(posedge clk);
            #1;
            checks++;
            if (a_ack !== vecs[i].e_a_ack || b_ack !== vecs[i].e_b_ack ||
                cfg !== vecs[i].e_cfg || cfg_valid !== vecs[i].e_valid ||
                pending !== vecs[i].e_pend || frame_cnt !== vecs[i].e_fc) begin
                errors++;
                $display("FAIL vec%0d: got a_ack=%b b_ack=%b cfg=%h valid=%b pend=%b fc=%h, want a_ack=%b b_ack=%b cfg=%h valid=%b pend=%b fc=%h",
                         i, a_ack, b_ack, cfg, cfg_valid, pending, frame_cnt,
                         vecs[i].e_a_ack, vecs[i].e_b_ack, vecs[i].e_cfg,
                         vecs[i].e_valid, vecs[i].e_pend, vecs[i].e_fc);
            end
        end

        // Frame counter wrap: all-ones plus one fall returns to zero.
        @(negedge clk);
        w_rst = 1'b1;
        @(negedge clk);
        w_rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            logic [WFCW-1:0] exp_fc;
            exp_fc = WFCW'(n % 8);
            @(negedge clk);
            w_vs = 1'b0;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (w_frame_cnt !== exp_fc || w_cfg_valid !== 1'b0 || w_pending !== 1'b0) begin
                errors++;
                $display("FAIL wrap fall%0d: got fc=%h valid=%b pend=%b, want fc=%h valid=0 pend=0",
                         n, w_frame_cnt, w_cfg_valid, w_pending, exp_fc);
            end
            w_vs = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
